// File: rtl/clk_align_seq_pkg.sv
// Shared types, widths and parameter defaults for the ECP3 DDR clock-alignment sequencer.
package clk_align_seq_pkg;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TRIES_W   = 4;
    localparam int unsigned TRIES_SAT = 15;

    localparam int unsigned DEF_STOP_CYCLES   = 8;
    localparam int unsigned DEF_RESET_CYCLES  = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_MAX_TRIES     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STOP      = 3'd2,
        ST_RST       = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    // Attempt counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [TRIES_W-1:0] tries_inc(input logic [TRIES_W-1:0] t);
        return (t == TRIES_W'(TRIES_SAT)) ? t : t + TRIES_W'(1);
    endfunction

endpackage

// File: rtl/clk_align_seq_if.sv
// Control/status bundle between the alignment sequencer and its environment.
interface clk_align_seq_if;
    import clk_align_seq_pkg::*;

    logic               lock;
    logic               start;
    logic               align_ok;
    logic               pll_stop;
    logic               reset_datapath;
    logic               done;
    logic               fail;
    logic [TRIES_W-1:0] tries;

    modport master (
        output lock, start, align_ok,
        input  pll_stop, reset_datapath, done, fail, tries
    );

    modport slave (
        input  lock, start, align_ok,
        output pll_stop, reset_datapath, done, fail, tries
    );
endinterface

// File: rtl/sync2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by async reset.
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clk_align_seq.sv
// Clock-alignment sequencer: repeatedly stops the PLL, resets the datapath and checks
// alignment until it succeeds or the attempt budget runs out.
module clk_align_seq
    import clk_align_seq_pkg::*;
#(
    parameter int unsigned STOP_CYCLES   = DEF_STOP_CYCLES,
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_TRIES     = DEF_MAX_TRIES
) (
    input  logic           eclk,
    input  logic           reset,
    clk_align_seq_if.slave bus
);
    localparam logic [CNT_W-1:0]   STOP_LOAD   = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(MAX_TRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    sync2ff u_lock_sync (
        .clk (eclk),
        .rst (reset),
        .d   (bus.lock),
        .q   (lock_s)
    );

    always_ff @(posedge eclk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bus.pll_stop       <= 1'b0;
            bus.reset_datapath <= 1'b1;
            bus.done           <= 1'b0;
            bus.fail           <= 1'b0;
            bus.tries          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_WAIT_LOCK;
                        bus.tries <= '0;
                        bus.done  <= 1'b0;
                        bus.fail  <= 1'b0;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state              <= ST_STOP;
                        cnt                <= STOP_LOAD;
                        bus.tries          <= tries_inc(bus.tries);
                        bus.pll_stop       <= 1'b1;
                        bus.reset_datapath <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (!lock_s) begin
                        state              <= ST_WAIT_LOCK;
                        bus.pll_stop       <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end else if (cnt == '0) begin
                        state        <= ST_RST;
                        cnt          <= RESET_LOAD;
                        bus.pll_stop <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_RST: begin
                    if (!lock_s) begin
                        state              <= ST_WAIT_LOCK;
                        bus.pll_stop       <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end else if (cnt == '0) begin
                        state              <= ST_SETTLE;
                        cnt                <= SETTLE_LOAD;
                        bus.reset_datapath <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (!lock_s) begin
                        state              <= ST_WAIT_LOCK;
                        bus.pll_stop       <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // >= rather than == so lock-loss retries past the budget still end in failure.
                ST_CHECK: begin
                    if (!lock_s) begin
                        state              <= ST_WAIT_LOCK;
                        bus.pll_stop       <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end else if (bus.align_ok) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                    end else if (bus.tries >= TRIES_LIMIT) begin
                        state              <= ST_FAIL;
                        bus.fail           <= 1'b1;
                        bus.reset_datapath <= 1'b1;
                    end else begin
                        state              <= ST_STOP;
                        cnt                <= STOP_LOAD;
                        bus.tries          <= tries_inc(bus.tries);
                        bus.pll_stop       <= 1'b1;
                        bus.reset_datapath <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.start) begin
                        state              <= ST_WAIT_LOCK;
                        bus.tries          <= '0;
                        bus.done           <= 1'b0;
                        bus.fail           <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end else if (!lock_s) begin
                        state              <= ST_WAIT_LOCK;
                        bus.done           <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end
                end

                ST_FAIL: begin
                    if (bus.start) begin
                        state              <= ST_WAIT_LOCK;
                        bus.tries          <= '0;
                        bus.done           <= 1'b0;
                        bus.fail           <= 1'b0;
                        bus.reset_datapath <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/clk_align_seq.md
CLK_ALIGN_SEQ -- requirements
Module: clk_align_seq

Interface
REQ-001 Parameter STOP_CYCLES, default 8: eclk cycles pll_stop is held high per attempt (range 1..255).
REQ-002 Parameter RESET_CYCLES, default 4: eclk cycles reset_datapath is held high after pll_stop falls (range 1..255).
REQ-003 Parameter SETTLE_CYCLES, default 16: eclk cycles between reset_datapath release and align_ok sampling (range 1..255).
REQ-004 Parameter MAX_TRIES, default 8: attempts before failure (range 1..15).
REQ-005 eclk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 lock  input  1  PLL lock, asynchronous, synchronised internally through 2 flops.
REQ-008 start  input  1  single-cycle request to begin an alignment sequence.
REQ-009 align_ok  input  1  downstream alignment good, valid only while sampled in CHECK.
REQ-010 pll_stop  output  1  clock-stop request to the stop generator.
REQ-011 reset_datapath  output  1  datapath reset to the stop generator.
REQ-012 done  output  1  alignment achieved, level.
REQ-013 fail  output  1  MAX_TRIES exhausted, level.
REQ-014 tries  output  4  attempts started since last start.

Function
REQ-015 States: IDLE, WAIT_LOCK, STOP, RST, SETTLE, CHECK, DONE, FAIL; one 8-bit down-counter shared by STOP/RST/SETTLE.
REQ-016 IDLE: reset_datapath=1, pll_stop=0; start -> WAIT_LOCK, tries<=0, done<=0, fail<=0.
REQ-017 WAIT_LOCK: on synchronised lock=1 -> STOP, tries<=tries+1, counter<=STOP_CYCLES-1.
REQ-018 STOP: pll_stop=1, reset_datapath=1 for exactly STOP_CYCLES cycles, then -> RST with counter<=RESET_CYCLES-1.
REQ-019 RST: pll_stop=0, reset_datapath=1 for exactly RESET_CYCLES cycles, then -> SETTLE with counter<=SETTLE_CYCLES-1.
REQ-020 SETTLE: reset_datapath=0 (this falling edge advances the stop generator's phase selection each attempt); after SETTLE_CYCLES cycles -> CHECK.
REQ-021 CHECK (one cycle): align_ok=1 -> DONE; else tries==MAX_TRIES -> FAIL; else -> STOP with counter reload and tries+1.
REQ-022 DONE: done=1, reset_datapath=0, pll_stop=0; held until start or reset.
REQ-023 FAIL: fail=1, reset_datapath=1, pll_stop=0; held until start or reset.
REQ-024 start in DONE or FAIL restarts per REQ-016; start in any other state is ignored.
REQ-025 Synchronised lock falling in STOP, RST, SETTLE or CHECK -> WAIT_LOCK, pll_stop=0, reset_datapath=1, tries unchanged; lock loss in DONE -> WAIT_LOCK, done=0.
REQ-026 tries saturates at 15; never wraps.
REQ-027 All outputs registered; done and fail never high together.

Reset
REQ-028 Asynchronous reset forces IDLE, pll_stop=0, reset_datapath=1, done=0, fail=0, tries=0, counter=0, lock synchroniser=0.
REQ-029 Reset asserted mid-sequence aborts immediately with REQ-028 values; no start is remembered.

Structure
REQ-030 State encoding constants and parameter default values belong in the shared ECP3 DDR package.
REQ-031 Lock synchroniser is a separate sub-module, sync2ff, 1-bit, async reset to 0.

Verification
REQ-032 Reset, lock=1, start pulse, align_ok=1 -> pll_stop high 8 cycles, reset_datapath high 12 cycles total, falls, done=1 at cycle 8+4+16+1 after STOP entry, tries=1.
REQ-033 align_ok=0 for attempts 1..3, 1 on 4 -> four reset_datapath falling edges, done=1, tries=4.
REQ-034 align_ok=0 always, MAX_TRIES=8 -> eight attempts, fail=1, done=0, tries=8, reset_datapath=1.
REQ-035 lock dropped for 5 cycles during STOP of attempt 2 -> pll_stop=0 within 3 cycles, WAIT_LOCK, resume with tries=3 on relock.
REQ-036 reset pulsed during SETTLE -> outputs at REQ-028 values same cycle; start while in STOP ignored (tries unchanged).
